// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller: FSM states,
// csr field positions and the receive FIFO entry.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ARM,
        ST_RUN
    } rx_state_t;

    localparam int CSR_LEN_LSB = 0;
    localparam int CSR_LEN_MSB = 3;
    localparam int CSR_STOP2   = 4;
    localparam int CSR_PAR_EN  = 5;
    localparam int CSR_PAR_ODD = 6;
    localparam int CSR_THR_LSB = 8;
    localparam int CSR_THR_MSB = 11;

    typedef struct packed {
        logic        pe;
        logic        fe;
        logic [31:0] data;
    } rx_entry_t;

    function automatic logic [3:0] irq_thresh(
        input logic [31:0] csr
    );
        return csr[CSR_THR_MSB:CSR_THR_LSB];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a pop frees its slot before a same-tick
// push, so a full FIFO with pop and push accepts the new word.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     tick,
    input  logic                     rst,
    input  logic                     push,
    input  rx_entry_t                push_data,
    input  logic                     pop,
    output rx_entry_t                head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_ok,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    rx_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;
    assign head    = mem[rd_ptr];

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge tick) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arm/run sequencing, csr, FIFO status, irq.
// Define UART_RX_ERRCNT_EN to add the pe_cnt/fe_cnt error counters.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int IDLE_TICKS = 16
) (
    input  logic                   tick,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_wr,
    input  logic [31:0]            cfg_in,
    input  logic                   line,
    output logic                   rx_rst,
    output logic [31:0]            rx_csr,
    input  logic                   rx_fifo_wr,
    input  logic [31:0]            rx_data,
    input  logic                   rx_pe,
    input  logic                   rx_fe,
    input  logic                   rd_en,
    output logic [31:0]            rd_data,
    output logic                   rd_pe,
    output logic                   rd_fe,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr,
    output logic                   irq
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0]             pe_cnt,
    output logic [7:0]             fe_cnt
`endif
);

    localparam int IW = $clog2(IDLE_TICKS + 1);

    rx_state_t     state_q;
    rx_state_t     state_d;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;
    logic          wr_q;
    logic          rise;
    logic          pend_vld;
    rx_entry_t     pend;
    rx_entry_t     head;
    logic          push_ok;
    logic          drop;
    logic [3:0]    thr;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        unique case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_ARM;
                    idle_d  = '0;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idle_d  = '0;
                end else if (cfg_wr || !line) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_TICKS - 1)) begin
                    state_d = ST_RUN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_OFF;
                end else if (cfg_wr) begin
                    state_d = ST_ARM;
                    idle_d  = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            idle_q  <= '0;
            rx_csr  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            if (cfg_wr)
                rx_csr <= cfg_in;
        end
    end

    assign rx_rst = (state_q != ST_RUN);
    assign rise   = rx_fifo_wr & ~wr_q;

    // Word is staged one tick so a held strobe pushes exactly once.
    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            pend_vld <= 1'b0;
            pend     <= '0;
        end else begin
            wr_q     <= rx_fifo_wr;
            pend_vld <= rise & (state_q == ST_RUN);
            if (rise)
                pend <= {rx_pe, rx_fe, rx_data};
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .tick      (tick),
        .rst       (rst),
        .push      (pend_vld),
        .push_data (pend),
        .pop       (rd_en),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .push_ok   (push_ok),
        .drop      (drop)
    );

    assign rd_data = head.data;
    assign rd_pe   = head.pe;
    assign rd_fe   = head.fe;
    assign thr     = irq_thresh(rx_csr);

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (clr)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            irq <= ((int'(level) >= int'(thr)) && (thr != 4'd0))
                   || overflow;
        end
    end

`ifdef UART_RX_ERRCNT_EN
    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            pe_cnt <= '0;
            fe_cnt <= '0;
        end else if (clr) begin
            pe_cnt <= '0;
            fe_cnt <= '0;
        end else if (push_ok) begin
            if (pend.pe && pe_cnt != 8'hff)
                pe_cnt <= pe_cnt + 8'd1;
            if (pend.fe && fe_cnt != 8'hff)
                fe_cnt <= fe_cnt + 8'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = push_ok;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int IDLE  = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int M_OFF = 0;
    localparam int M_ARM = 1;
    localparam int M_RUN = 2;

    logic          tick = 1'b0;
    logic          rst, en, cfg_wr, line;
    logic [31:0]   cfg_in, rx_data;
    logic          rx_fifo_wr, rx_pe, rx_fe, rd_en, clr;
    logic          rx_rst, rd_pe, rd_fe, empty, full;
    logic          overflow, irq;
    logic [31:0]   rx_csr, rd_data;
    logic [LW-1:0] level;
`ifdef UART_RX_ERRCNT_EN
    logic [7:0]    pe_cnt, fe_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    int          m_mode, m_high, m_pe, m_fe;
    logic [31:0] m_csr;
    logic [33:0] m_q[$];
    bit          m_ovf, m_irq, m_prev_wr, m_pend;
    logic [33:0] m_pend_w;

    uart_rx_ctrl #(
        .DEPTH      (DEPTH),
        .IDLE_TICKS (IDLE)
    ) dut (
        .tick       (tick),
        .rst        (rst),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_in     (cfg_in),
        .line       (line),
        .rx_rst     (rx_rst),
        .rx_csr     (rx_csr),
        .rx_fifo_wr (rx_fifo_wr),
        .rx_data    (rx_data),
        .rx_pe      (rx_pe),
        .rx_fe      (rx_fe),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_pe      (rd_pe),
        .rd_fe      (rd_fe),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .clr        (clr),
        .irq        (irq)
`ifdef UART_RX_ERRCNT_EN
        ,
        .pe_cnt     (pe_cnt),
        .fe_cnt     (fe_cnt)
`endif
    );

    always #5 tick = ~tick;

    task automatic model_reset();
        m_mode = M_OFF; m_high = 0; m_csr = '0;
        m_q.delete();
        m_ovf = 0; m_irq = 0; m_prev_wr = 0; m_pend = 0;
        m_pend_w = '0; m_pe = 0; m_fe = 0;
    endtask

    // One tick: evaluate spec rules on current inputs, then advance.
    task automatic cyc();
        int thr, n, nm, nh, npe, nfe;
        bit pop_ok, acc, novf, nirq, npend;
        logic [33:0] nw, w;
        logic [31:0] ncsr;
        n = m_q.size();
        thr = int'(m_csr[11:8]);
        nirq = (thr != 0 && n >= thr) || m_ovf;
        pop_ok = rd_en && n > 0;
        acc = m_pend && (n < DEPTH || pop_ok);
        novf = clr ? 1'b0 : ((m_pend && !acc) ? 1'b1 : m_ovf);
        npe = m_pe; nfe = m_fe;
        if (clr) begin
            npe = 0; nfe = 0;
        end else if (acc) begin
            if (m_pend_w[33] && npe < 255) npe++;
            if (m_pend_w[32] && nfe < 255) nfe++;
        end
        npend = (m_mode == M_RUN) && rx_fifo_wr && !m_prev_wr;
        nw = npend ? {rx_pe, rx_fe, rx_data} : m_pend_w;
        ncsr = cfg_wr ? cfg_in : m_csr;
        nm = m_mode; nh = m_high;
        if (m_mode == M_OFF) begin
            if (en) begin nm = M_ARM; nh = 0; end
        end else if (!en) begin
            nm = M_OFF; nh = 0;
        end else if (cfg_wr) begin
            nm = M_ARM; nh = 0;
        end else if (m_mode == M_ARM) begin
            if (line) begin
                nh = m_high + 1;
                if (nh == IDLE) begin nm = M_RUN; nh = 0; end
            end else begin
                nh = 0;
            end
        end
        @(posedge tick);
        #1;
        if (pop_ok) w = m_q.pop_front();
        if (acc) m_q.push_back(m_pend_w);
        m_ovf = novf; m_irq = nirq; m_pe = npe; m_fe = nfe;
        m_pend = npend; m_pend_w = nw; m_prev_wr = rx_fifo_wr;
        m_csr = ncsr; m_mode = nm; m_high = nh;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge tick);
        #1;
        rst = 1'b0;
        rx_fifo_wr = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input logic [31:0] d, input bit pe, input bit fe);
        rx_data = d; rx_pe = pe; rx_fe = fe;
        rx_fifo_wr = 1'b1;
        cyc();
        rx_fifo_wr = 1'b0;
        cyc();
    endtask

    task automatic rearm();
        int i;
        en = 1'b1; line = 1'b1;
        for (i = 0; i < 40 && rx_rst !== 1'b0; i++) cyc();
        checks++;
        if (rx_rst !== 1'b0) begin
            $display("FAIL rearm_timeout rx_rst=%b want 0", rx_rst);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 0; cfg_wr = 0; cfg_in = 0; line = 1;
        rx_fifo_wr = 0; rx_data = 0; rx_pe = 0; rx_fe = 0;
        rd_en = 0; clr = 0;
        repeat (2) @(posedge tick);
        #1;
        checks++;
        if ({rx_rst, empty, full, overflow, irq} !== 5'b11000) begin
            $display("FAIL reset_flags got %b%b%b%b%b want 11000",
                     rx_rst, empty, full, overflow, irq);
            fails++;
        end
        checks++;
        if (rx_csr !== 32'h0 || level !== '0) begin
            $display("FAIL reset_csr_level csr=%h lvl=%0d want 0 0",
                     rx_csr, level);
            fails++;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_arm();
        en = 1'b1; line = 1'b1;
        cyc();
        for (int i = 1; i <= 9; i++) cyc();
        line = 1'b0;
        cyc();
        line = 1'b1;
        for (int i = 1; i <= IDLE; i++) begin
            cyc();
            checks++;
            if (rx_rst !== (i < IDLE)) begin
                $display("FAIL arm_tick%0d rx_rst=%b want %b",
                         i, rx_rst, (i < IDLE));
                fails++;
            end
        end
    endtask

    task automatic test_order();
        logic [31:0] exp [3];
        exp[0] = 32'h11111111;
        exp[1] = 32'h22222222;
        exp[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            rx_data = exp[i]; rx_pe = 0; rx_fe = 0;
            rx_fifo_wr = 1'b1;
            cyc();
            checks++;
            if (level !== LW'(i)) begin
                $display("FAIL push_latency lvl=%0d want %0d", level, i);
                fails++;
            end
            cyc(); cyc();
            rx_fifo_wr = 1'b0;
            cyc();
            checks++;
            if (level !== LW'(i + 1)) begin
                $display("FAIL push_once lvl=%0d want %0d", level, i + 1);
                fails++;
            end
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== exp[i] || level !== LW'(3 - i)) begin
                $display("FAIL pop_order%0d data=%h lvl=%0d want %h %0d",
                         i, rd_data, level, exp[i], 3 - i);
                fails++;
            end
            cyc();
        end
        cyc();
        rd_en = 1'b0;
        checks++;
        if (level !== '0 || empty !== 1'b1) begin
            $display("FAIL drain lvl=%0d empty=%b want 0 1", level, empty);
            fails++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        for (int i = 0; i < 9; i++) pulse(32'hA0 + i, 0, 0);
        checks++;
        if (level !== LW'(DEPTH) || full !== 1 || overflow !== 1) begin
            $display("FAIL ovf_set lvl=%0d full=%b ovf=%b want 8 1 1",
                     level, full, overflow);
            fails++;
        end
        cyc();
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL ovf_irq irq=%b want 1", irq);
            fails++;
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
        checks++;
        if (overflow !== 1'b0 || irq !== 1'b0) begin
            $display("FAIL ovf_clr ovf=%b irq=%b want 0 0", overflow, irq);
            fails++;
        end
        rx_data = 32'hBEEF; rx_fifo_wr = 1'b1;
        cyc();
        rx_fifo_wr = 1'b0; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (level !== LW'(DEPTH) || overflow !== 1'b0) begin
            $display("FAIL full_pushpop lvl=%0d ovf=%b want 8 0",
                     level, overflow);
            fails++;
        end
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i < DEPTH - 1) ? 32'hA1 + i : 32'hBEEF;
            checks++;
            if (rd_data !== exp) begin
                $display("FAIL full_contents%0d data=%h want %h",
                         i, rd_data, exp);
                fails++;
            end
            cyc();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_irq_cfg();
        cfg_in = 32'h0000_0463; cfg_wr = 1'b1;
        cyc();
        cfg_wr = 1'b0;
        checks++;
        if (rx_csr !== 32'h463 || rx_rst !== 1'b1) begin
            $display("FAIL cfg_load csr=%h rst=%b want 463 1",
                     rx_csr, rx_rst);
            fails++;
        end
        for (int i = 1; i <= IDLE; i++) begin
            cyc();
            checks++;
            if (rx_rst !== (i < IDLE)) begin
                $display("FAIL cfg_hold%0d rx_rst=%b want %b",
                         i, rx_rst, (i < IDLE));
                fails++;
            end
        end
        for (int i = 0; i < 4; i++) pulse(32'hC0 + i, 0, 0);
        checks++;
        if (level !== LW'(4) || irq !== 1'b0) begin
            $display("FAIL irq_early lvl=%0d irq=%b want 4 0", level, irq);
            fails++;
        end
        cyc();
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_rise irq=%b want 1", irq);
            fails++;
        end
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        cyc();
        checks++;
        if (level !== LW'(3) || irq !== 1'b0) begin
            $display("FAIL irq_fall lvl=%0d irq=%b want 3 0", level, irq);
            fails++;
        end
        rd_en = 1'b1;
        repeat (3) cyc();
        rd_en = 1'b0;
    endtask

    task automatic test_outside_run();
        pulse(32'h5A5A5A5A, 1, 0);
        en = 1'b0;
        cyc();
        pulse(32'h12345678, 0, 0);
        checks++;
        if (level !== LW'(1) || rx_rst !== 1'b1) begin
            $display("FAIL off_ignore lvl=%0d rst=%b want 1 1",
                     level, rx_rst);
            fails++;
        end
        rearm();
        checks++;
        if (rd_data !== 32'h5A5A5A5A || rd_pe !== 1 || rd_fe !== 0) begin
            $display("FAIL retain data=%h pe=%b fe=%b want 5a5a5a5a 1 0",
                     rd_data, rd_pe, rd_fe);
            fails++;
        end
    endtask

    task automatic test_reset_midpush();
        rx_data = 32'hDEAD; rx_fifo_wr = 1'b1;
        cyc();
        do_reset();
        cyc();
        checks++;
        if (level !== '0 || empty !== 1'b1 || rx_csr !== '0) begin
            $display("FAIL rst_flush lvl=%0d empty=%b csr=%h want 0 1 0",
                     level, empty, rx_csr);
            fails++;
        end
    endtask

    task automatic test_random();
        int bias;
        bias = 1;
        rearm();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) bias = $urandom_range(0, 2);
            en = ($urandom_range(0, 299) != 0);
            line = ($urandom_range(0, 15) != 0);
            cfg_wr = ($urandom_range(0, 249) == 0);
            cfg_in = $urandom;
            clr = ($urandom_range(0, 99) == 0);
            rx_fifo_wr = ($urandom_range(0, 1) == 0);
            rx_data = $urandom;
            rx_pe = $urandom_range(0, 1) == 0;
            rx_fe = $urandom_range(0, 3) == 0;
            rd_en = ($urandom_range(0, 3) < bias + 1);
            cyc();
            checks++;
            if (rx_rst !== (m_mode != M_RUN) || rx_csr !== m_csr) begin
                $display("FAIL rnd_ctl c=%0d rst=%b csr=%h want %b %h",
                         c, rx_rst, rx_csr, (m_mode != M_RUN), m_csr);
                fails++;
            end
            checks++;
            if (level !== LW'(m_q.size()) ||
                empty !== (m_q.size() == 0) ||
                full !== (m_q.size() == DEPTH)) begin
                $display("FAIL rnd_lvl c=%0d lvl=%0d want %0d",
                         c, level, m_q.size());
                fails++;
            end
            checks++;
            if (overflow !== m_ovf || irq !== m_irq) begin
                $display("FAIL rnd_irq c=%0d ovf=%b irq=%b want %b %b",
                         c, overflow, irq, m_ovf, m_irq);
                fails++;
            end
            if (m_q.size() > 0) begin
                checks++;
                if ({rd_pe, rd_fe, rd_data} !== m_q[0]) begin
                    $display("FAIL rnd_head c=%0d got %h want %h",
                             c, {rd_pe, rd_fe, rd_data}, m_q[0]);
                    fails++;
                end
            end
`ifdef UART_RX_ERRCNT_EN
            checks++;
            if (pe_cnt !== 8'(m_pe) || fe_cnt !== 8'(m_fe)) begin
                $display("FAIL rnd_cnt c=%0d pe=%0d fe=%0d want %0d %0d",
                         c, pe_cnt, fe_cnt, m_pe, m_fe);
                fails++;
            end
`endif
        end
        cfg_wr = 0; clr = 0; rx_fifo_wr = 0; rd_en = 0;
        cyc();
    endtask

`ifdef UART_RX_ERRCNT_EN
    task automatic test_errcnt();
        do_reset();
        rearm();
        rd_en = 1'b1;
        for (int i = 0; i < 300; i++) pulse($urandom, 1, 0);
        checks++;
        if (pe_cnt !== 8'd255 || fe_cnt !== 8'd0) begin
            $display("FAIL errcnt_sat pe=%0d fe=%0d want 255 0",
                     pe_cnt, fe_cnt);
            fails++;
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (pe_cnt !== 8'd0) begin
            $display("FAIL errcnt_clr pe=%0d want 0", pe_cnt);
            fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arm();
        test_order();
        test_overflow();
        test_irq_cfg();
        test_outside_run();
        test_reset_midpush();
        test_random();
`ifdef UART_RX_ERRCNT_EN
        test_errcnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
